// File: rtl/mptw_mem_arbiter_pkg.sv
// rtl/mptw_mem_arbiter_pkg.sv - shared types for the MPT-walker memory arbiter
// Purpose: FSM state encoding, the ID FIFO entry type and a small sizing helper.
// Ports: none (package).
package mptw_mem_arbiter_pkg;

    // Requester index field width inside an ID FIFO entry; covers up to 16 requesters.
    localparam int unsigned MPTW_ARB_IDX_W = 4;

    typedef enum logic {
        MPTW_ARB_RUN   = 1'b0,
        MPTW_ARB_DRAIN = 1'b1
    } mptw_arb_state_e;

    // One entry per in-flight read: who issued it and whether its data is discarded.
    typedef struct packed {
        logic                      drop;
        logic [MPTW_ARB_IDX_W-1:0] idx;
    } mptw_arb_id_t;

    // Pointer width that never collapses to zero bits for a depth of one.
    function automatic int unsigned mptw_clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mptw_mem_arbiter_id_fifo.sv
// rtl/mptw_mem_arbiter_id_fifo.sv - in-order FIFO of issued-read IDs
// Purpose: remembers the issuer (and drop flag) of each outstanding memory read.
// Ports: clk_i/rst_ni clock and async active-low reset; push_i/push_data_i write side;
//        pop_i/pop_data_o read side (head visible while not empty);
//        full_o/empty_o/count_o occupancy.
module mptw_mem_arbiter_id_fifo
    import mptw_mem_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1),
    localparam int unsigned PTR_W = mptw_clog2_min1(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  mptw_arb_id_t     push_data_i,
    input  logic             pop_i,
    output mptw_arb_id_t     pop_data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    mptw_arb_id_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == CNT_W'(DEPTH));
    assign count_o    = count_q;
    assign pop_data_o = mem_q[rd_ptr_q];

    // Pop on empty is ignored; a full FIFO still accepts a push when it pops in the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (do_push && !do_pop)      count_q <= count_q + CNT_W'(1);
            else if (do_pop && !do_push) count_q <= count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/mptw_mem_arbiter.sv
// rtl/mptw_mem_arbiter.sv - round-robin share of the MPT-walker memory read port
// Purpose: arbitrates NUM_REQ walk requesters onto one in-order read port, routes each
//          response back to its issuer, and drains/discards in-flight reads on flush.
// Ports: clk_i/rst_ni clock and async active-low reset; flush_i drain request;
//        req_valid_i/req_addr_i/req_ready_o requester side (ready one-hot at handshake);
//        rsp_valid_o/rsp_data_o/rsp_err_o registered one-hot response;
//        mem_req_* memory request channel; mem_rsp_* in-order memory response;
//        busy_o reads outstanding or draining.
module mptw_mem_arbiter
    import mptw_mem_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ         = 4,
    parameter int unsigned ADDR_WIDTH      = 56,
    parameter int unsigned DATA_WIDTH      = 64,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          flush_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic [NUM_REQ-1:0]            rsp_valid_o,
    output logic [DATA_WIDTH-1:0]         rsp_data_o,
    output logic                          rsp_err_o,
    output logic                          mem_req_valid_o,
    input  logic                          mem_req_ready_i,
    output logic [ADDR_WIDTH-1:0]         mem_req_addr_o,
    input  logic                          mem_rsp_valid_i,
    input  logic [DATA_WIDTH-1:0]         mem_rsp_data_i,
    input  logic                          mem_rsp_err_i,
    output logic                          busy_o
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

    mptw_arb_state_e       state_q, state_d;
    logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic                  lock_q, lock_d;
    logic [IDX_W-1:0]      lock_idx_q, lock_idx_d;
    logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                  rsp_err_q, rsp_err_d;

    logic [ADDR_WIDTH-1:0] req_addr_arr [NUM_REQ];
    logic                  arb_found;
    logic [IDX_W-1:0]      arb_idx;
    logic [IDX_W:0]        cand;
    logic [IDX_W-1:0]      issue_idx;
    logic                  handshake;

    logic                  fifo_full, fifo_empty;
    logic [CNT_W-1:0]      fifo_count;
    mptw_arb_id_t          push_id, head_id;
    logic                  rsp_take, rsp_drop;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_addr
        assign req_addr_arr[g] = req_addr_i[g*ADDR_WIDTH +: ADDR_WIDTH];
    end

    // Round-robin: first valid requester at or after rr_ptr_q. cand carries one extra
    // bit so rr_ptr + i can be wrapped without modulo for non-power-of-two NUM_REQ.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(i);
            if (cand >= (IDX_W+1)'(NUM_REQ)) cand = cand - (IDX_W+1)'(NUM_REQ);
            if (!arb_found && req_valid_i[cand[IDX_W-1:0]]) begin
                arb_found = 1'b1;
                arb_idx   = cand[IDX_W-1:0];
            end
        end
    end

    // A stalled request keeps its grant until accepted, even across a flush.
    assign issue_idx       = lock_q ? lock_idx_q : arb_idx;
    assign mem_req_valid_o = lock_q
                           | ((state_q == MPTW_ARB_RUN) && !flush_i && !fifo_full && arb_found);
    assign mem_req_addr_o  = req_addr_arr[issue_idx];
    assign handshake       = mem_req_valid_o && mem_req_ready_i;

    always_comb begin
        req_ready_o = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready_o[i] = handshake && (issue_idx == IDX_W'(i));
        end
    end

    // A read issued while flushing or draining belongs to the old context.
    assign push_id.drop = flush_i || (state_q == MPTW_ARB_DRAIN);
    assign push_id.idx  = MPTW_ARB_IDX_W'(issue_idx);

    mptw_mem_arbiter_id_fifo #(
        .DEPTH(MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .push_i     (handshake),
        .push_data_i(push_id),
        .pop_i      (mem_rsp_valid_i),
        .pop_data_o (head_id),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (fifo_count)
    );

    assign rsp_take = mem_rsp_valid_i && !fifo_empty;
    assign rsp_drop = head_id.drop || (state_q == MPTW_ARB_DRAIN) || flush_i;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        lock_d      = lock_q;
        lock_idx_d  = lock_idx_q;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            MPTW_ARB_RUN:   if (flush_i) state_d = MPTW_ARB_DRAIN;
            MPTW_ARB_DRAIN: if (fifo_count == '0 && !flush_i && !lock_q) state_d = MPTW_ARB_RUN;
            default:        state_d = MPTW_ARB_RUN;
        endcase

        if (handshake) begin
            lock_d   = 1'b0;
            rr_ptr_d = (issue_idx == IDX_W'(NUM_REQ - 1)) ? '0 : issue_idx + 1'b1;
        end else if (mem_req_valid_o) begin
            lock_d     = 1'b1;
            lock_idx_d = issue_idx;
        end

        if (rsp_take) begin
            rsp_data_d = mem_rsp_data_i;
            rsp_err_d  = mem_rsp_err_i;
            if (!rsp_drop) begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    rsp_valid_d[i] = (head_id.idx == MPTW_ARB_IDX_W'(i));
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= MPTW_ARB_RUN;
            rr_ptr_q    <= '0;
            lock_q      <= 1'b0;
            lock_idx_q  <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            lock_q      <= lock_d;
            lock_idx_q  <= lock_idx_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_err_o   = rsp_err_q;
    assign busy_o      = (fifo_count != '0) || (state_q == MPTW_ARB_DRAIN);

    // Memory must never answer a read that was not issued.
    a_no_spurious_rsp: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                        !(mem_rsp_valid_i && fifo_empty));

endmodule

// File: tb/tb_mptw_mem_arbiter.sv
// tb/tb_mptw_mem_arbiter.sv - directed scoreboard bench for mptw_mem_arbiter
module tb_mptw_mem_arbiter;

    localparam int NR = 4;
    localparam int AW = 56;
    localparam int DW = 64;
    localparam int MO = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              flush = 1'b0;
    logic [NR-1:0]     req_valid = '0;
    logic [AW-1:0]     addr [NR];
    logic [NR*AW-1:0]  req_addr;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     rsp_valid;
    logic [DW-1:0]     rsp_data;
    logic              rsp_err;
    logic              mem_req_valid;
    logic              mem_req_ready = 1'b0;
    logic [AW-1:0]     mem_req_addr;
    logic              mem_rsp_valid = 1'b0;
    logic [DW-1:0]     mem_rsp_data = '0;
    logic              mem_rsp_err = 1'b0;
    logic              busy;

    int checks = 0;
    int errors = 0;

    int          iss_idx_q  [$];
    bit          iss_drop_q [$];
    logic [3:0]  exp_mask_q [$];
    logic [63:0] exp_data_q [$];
    logic        exp_err_q  [$];

    assign req_addr = {addr[3], addr[2], addr[1], addr[0]};

    always #5 clk = ~clk;

    mptw_mem_arbiter #(
        .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .flush_i        (flush),
        .req_valid_i    (req_valid),
        .req_addr_i     (req_addr),
        .req_ready_o    (req_ready),
        .rsp_valid_o    (rsp_valid),
        .rsp_data_o     (rsp_data),
        .rsp_err_o      (rsp_err),
        .mem_req_valid_o(mem_req_valid),
        .mem_req_ready_i(mem_req_ready),
        .mem_req_addr_o (mem_req_addr),
        .mem_rsp_valid_i(mem_rsp_valid),
        .mem_rsp_data_i (mem_rsp_data),
        .mem_rsp_err_i  (mem_rsp_err),
        .busy_o         (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expect requester idx on the memory port this cycle; record it if the handshake happens.
    task automatic expect_issue(input string tag, input int idx);
        #1;
        chk({tag, " valid"}, 64'(mem_req_valid), 64'd1);
        chk({tag, " addr"}, 64'(mem_req_addr), 64'(addr[idx]));
        chk({tag, " ready"}, 64'(req_ready), mem_req_ready ? 64'(4'b1 << idx) : 64'd0);
        if (mem_req_ready) begin
            iss_idx_q.push_back(idx);
            iss_drop_q.push_back(1'b0);
        end
    endtask

    task automatic expect_idle(input string tag);
        #1;
        chk({tag, " valid"}, 64'(mem_req_valid), 64'd0);
        chk({tag, " ready"}, 64'(req_ready), 64'd0);
    endtask

    // Memory returns the oldest outstanding read; the expected routing comes from the issue model.
    task automatic drive_rsp(input logic [63:0] data, input logic err);
        int  idx;
        bit  drop;
        if (iss_idx_q.size() == 0) begin
            errors++;
            $display("FAIL rsp_model no outstanding read to answer");
            return;
        end
        idx  = iss_idx_q.pop_front();
        drop = iss_drop_q.pop_front();
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = data;
        mem_rsp_err   = err;
        exp_mask_q.push_back(drop ? 4'b0 : 4'(4'b1 << idx));
        exp_data_q.push_back(data);
        exp_err_q.push_back(err);
    endtask

    task automatic tick();
        logic       had;
        logic [3:0] m;
        had = mem_rsp_valid;
        @(posedge clk);
        #1;
        mem_rsp_valid = 1'b0;
        mem_rsp_err   = 1'b0;
        if (had && exp_mask_q.size() > 0) begin
            m = exp_mask_q.pop_front();
            chk("rsp_valid", 64'(rsp_valid), 64'(m));
            if (m != 4'b0) begin
                chk("rsp_data", rsp_data, exp_data_q[0]);
                chk("rsp_err", 64'(rsp_err), 64'(exp_err_q[0]));
            end
            void'(exp_data_q.pop_front());
            void'(exp_err_q.pop_front());
        end else begin
            chk("rsp_idle", 64'(rsp_valid), 64'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        addr[0] = 56'h0000_0100;
        addr[1] = 56'h0000_0200;
        addr[2] = 56'h0000_0300;
        addr[3] = 56'h0000_0400;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst rsp_err", 64'(rsp_err), 64'd0);
        chk("rst rsp_data", rsp_data, 64'd0);
        chk("rst mem_req_valid", 64'(mem_req_valid), 64'd0);
        chk("rst req_ready", 64'(req_ready), 64'd0);
        chk("rst busy", 64'(busy), 64'd0);
        rst_n = 1'b1;

        // Two requesters, back-to-back issue, responses routed in order
        req_valid = 4'b0101; mem_req_ready = 1'b1;
        expect_issue("t1_g0", 0); tick();
        req_valid = 4'b0100;
        expect_issue("t1_g2", 2); tick();
        req_valid = 4'b0000;
        drive_rsp(64'hA0, 1'b0); tick();
        drive_rsp(64'hA2, 1'b0); tick();
        #1 chk("t1 busy", 64'(busy), 64'd0);

        // Fairness with wrap; one response per cycle overlaps each new issue
        rst_n = 1'b0; #1; rst_n = 1'b1;
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) drive_rsp(64'hB00 + 64'(k), 1'b0);
            expect_issue($sformatf("t2_g%0d", k), k % 4);
            tick();
        end
        req_valid = 4'b0000;
        drive_rsp(64'hB08, 1'b0); tick();

        // Stall: grant, address and index held while a preferred requester appears
        addr[1] = 56'h1000;
        req_valid = 4'b0010; mem_req_ready = 1'b0;
        expect_issue("t3_hold0", 1); tick();
        req_valid = 4'b1010;
        expect_issue("t3_hold1", 1); tick();
        req_valid = 4'b1011;
        expect_issue("t3_hold2", 1); tick();
        mem_req_ready = 1'b1;
        expect_issue("t3_accept", 1); tick();
        req_valid = 4'b1001;
        expect_issue("t3_next3", 3); tick();
        req_valid = 4'b0001;
        expect_issue("t3_next0", 0); tick();
        req_valid = 4'b0000;
        drive_rsp(64'hC1, 1'b0); tick();
        drive_rsp(64'hC3, 1'b0); tick();
        drive_rsp(64'hC0, 1'b0); tick();

        // Fill to MAX_OUTSTANDING, then pop/push around the full boundary
        req_valid = 4'b1111;
        expect_issue("t4_g1", 1); tick();
        expect_issue("t4_g2", 2); tick();
        expect_issue("t4_g3", 3); tick();
        expect_issue("t4_g0", 0); tick();
        drive_rsp(64'hD1, 1'b0);
        expect_idle("t4_full"); tick();
        drive_rsp(64'hD2, 1'b0);
        expect_issue("t4_pushpop", 1); tick();
        expect_issue("t4_refill", 2); tick();
        expect_idle("t4_full_again"); tick();
        req_valid = 4'b0000;
        #1 chk("t4 busy", 64'(busy), 64'd1);
        drive_rsp(64'hD3, 1'b0); tick();
        drive_rsp(64'hD4, 1'b0); tick();
        drive_rsp(64'hD5, 1'b0); tick();
        drive_rsp(64'hD6, 1'b0); tick();

        // Flush with two reads in flight: data discarded, issue resumes once drained
        req_valid = 4'b1111;
        expect_issue("t5_g3", 3); tick();
        expect_issue("t5_g0", 0); tick();
        req_valid = 4'b0000;
        flush = 1'b1;
        foreach (iss_drop_q[i]) iss_drop_q[i] = 1'b1;
        expect_idle("t5_flush");
        chk("t5 busy flush", 64'(busy), 64'd1);
        tick();
        flush = 1'b0; mem_req_ready = 1'b0; req_valid = 4'b0001;
        drive_rsp(64'hE3, 1'b0);
        expect_idle("t5_drain0"); tick();
        drive_rsp(64'hE0, 1'b0);
        expect_idle("t5_drain1"); tick();
        expect_idle("t5_drain2"); tick();
        chk("t5 busy clear", 64'(busy), 64'd0);
        mem_req_ready = 1'b1;
        expect_issue("t5_resume", 0); tick();
        req_valid = 4'b0000;
        drive_rsp(64'hE5, 1'b0); tick();

        // Error response for requester 2, then asynchronous reset mid-operation
        req_valid = 4'b0100;
        expect_issue("t6_g2", 2); tick();
        req_valid = 4'b0001;
        drive_rsp(64'hF2, 1'b1);
        expect_issue("t6_g0", 0); tick();
        req_valid = 4'b0000;
        #1 chk("t6 busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("arst rsp_valid", 64'(rsp_valid), 64'd0);
        chk("arst rsp_err", 64'(rsp_err), 64'd0);
        chk("arst rsp_data", rsp_data, 64'd0);
        chk("arst busy", 64'(busy), 64'd0);
        chk("arst mem_req_valid", 64'(mem_req_valid), 64'd0);
        chk("arst req_ready", 64'(req_ready), 64'd0);
        iss_idx_q.delete();
        iss_drop_q.delete();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
